// File: rtl/instr_chain_loader_pkg.sv
// Shared types and width constants for the cell instruction-load chain host.
// Widths mirror the cell package so chain fields line up bit-for-bit.
package instr_chain_loader_pkg;

    localparam int CELL_DATA_W = 32;
    localparam int CELL_ADDR_W = 6;
    localparam int CELL_HOPS_W = 4;
    localparam int RUN_W       = 32;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CALL  = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_HOPS    = 2'd1,
        ERR_STALE   = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_t;

endpackage

// File: rtl/instr_chain_loader.sv
// Streams load records onto the cell chain, drains it, then runs a call/ret
// handshake with the fabric row and reports cycle count, completion and errors.
module instr_chain_loader
    import instr_chain_loader_pkg::*;
#(
    parameter int INSTR_DATA_WIDTH = instr_chain_loader_pkg::CELL_DATA_W,
    parameter int INSTR_ADDR_WIDTH = instr_chain_loader_pkg::CELL_ADDR_W,
    parameter int INSTR_HOPS_WIDTH = instr_chain_loader_pkg::CELL_HOPS_W,
    parameter int NUM_CELLS        = 16,
    parameter int DRAIN_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES   = 1 << 20
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ld_valid,
    output logic                        ld_ready,
    input  logic [INSTR_DATA_WIDTH-1:0] ld_data,
    input  logic [INSTR_ADDR_WIDTH-1:0] ld_addr,
    input  logic [INSTR_HOPS_WIDTH-1:0] ld_hops,
    input  logic                        ld_last,
    output logic [INSTR_DATA_WIDTH-1:0] instr_data_out,
    output logic [INSTR_ADDR_WIDTH-1:0] instr_addr_out,
    output logic [INSTR_HOPS_WIDTH-1:0] instr_hops_out,
    output logic                        instr_en_out,
    output logic                        call_out,
    input  logic                        ret_in,
    output logic                        busy,
    output logic                        done,
    output logic [1:0]                  err,
    output logic [31:0]                 run_cycles
);

    localparam logic [RUN_W-1:0] DRAIN_LOAD   = RUN_W'(DRAIN_CYCLES - 1);
    localparam logic [RUN_W-1:0] TIMEOUT_LAST = RUN_W'(TIMEOUT_CYCLES - 1);

    state_t                      r_state;
    err_t                        r_err;
    logic [RUN_W-1:0]            r_cnt;
    logic [RUN_W-1:0]            r_run_cycles;
    logic                        r_ld_ready;
    logic                        r_busy;
    logic                        r_done;
    logic                        r_call;
    logic                        r_instr_en;
    logic [INSTR_DATA_WIDTH-1:0] r_instr_data;
    logic [INSTR_ADDR_WIDTH-1:0] r_instr_addr;
    logic [INSTR_HOPS_WIDTH-1:0] r_instr_hops;

    logic w_accept;
    logic w_hops_ok;

    assign w_accept  = ld_valid && r_ld_ready;
    // Hops field may be wider than the cell index range when NUM_CELLS is not a power of two.
    assign w_hops_ok = (RUN_W'(ld_hops) < RUN_W'(NUM_CELLS));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_LOAD;
            r_err        <= ERR_NONE;
            r_cnt        <= '0;
            r_run_cycles <= '0;
            r_ld_ready   <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_call       <= 1'b0;
            r_instr_en   <= 1'b0;
            r_instr_data <= '0;
            r_instr_addr <= '0;
            r_instr_hops <= '0;
        end else begin
            r_instr_en <= 1'b0;
            r_call     <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    if (w_accept) begin
                        if (w_hops_ok) begin
                            r_instr_data <= ld_data;
                            r_instr_addr <= ld_addr;
                            r_instr_hops <= ld_hops;
                            r_instr_en   <= 1'b1;
                            r_err        <= ERR_NONE;
                        end else begin
                            r_err <= ERR_HOPS;
                        end
                        if (ld_last) begin
                            r_state    <= ST_DRAIN;
                            r_cnt      <= DRAIN_LOAD;
                            r_ld_ready <= 1'b0;
                            r_busy     <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (r_cnt == '0) begin
                        r_state      <= ST_CALL;
                        r_call       <= 1'b1;
                        r_run_cycles <= '0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_CALL: begin
                    // A ret already high here is left over from a previous run.
                    if (ret_in) begin
                        r_err      <= ERR_STALE;
                        r_done     <= 1'b1;
                        r_state    <= ST_LOAD;
                        r_ld_ready <= 1'b1;
                        r_busy     <= 1'b0;
                    end else begin
                        r_state <= ST_WAIT;
                        r_cnt   <= '0;
                    end
                end
                ST_WAIT: begin
                    r_cnt        <= r_cnt + 1'b1;
                    r_run_cycles <= r_cnt + 1'b1;
                    if (ret_in || (r_cnt == TIMEOUT_LAST)) begin
                        if (!ret_in) begin
                            r_err <= ERR_TIMEOUT;
                        end
                        r_done     <= 1'b1;
                        r_state    <= ST_LOAD;
                        r_ld_ready <= 1'b1;
                        r_busy     <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_LOAD;
                    r_ld_ready <= 1'b1;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign ld_ready       = r_ld_ready;
    assign busy           = r_busy;
    assign done           = r_done;
    assign call_out       = r_call;
    assign err            = r_err;
    assign run_cycles     = r_run_cycles;
    assign instr_en_out   = r_instr_en;
    assign instr_data_out = r_instr_data;
    assign instr_addr_out = r_instr_addr;
    assign instr_hops_out = r_instr_hops;

endmodule

// File: tb/tb_instr_chain_loader.sv
// Scenario bench for instr_chain_loader: programs, ret timing, errors and reset,
// checked against expectations derived from the load/drain/call/ret rules.
module tb_instr_chain_loader;
    import instr_chain_loader_pkg::*;

    localparam int NC = 12;
    localparam int DR = 16;
    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [31:0] ld_data = '0;
    logic [5:0]  ld_addr = '0;
    logic [3:0]  ld_hops = '0;
    logic        ld_last = 1'b0;
    logic [31:0] instr_data_out;
    logic [5:0]  instr_addr_out;
    logic [3:0]  instr_hops_out;
    logic        instr_en_out;
    logic        call_out;
    logic        ret_in = 1'b0;
    logic        busy;
    logic        done;
    logic [1:0]  err;
    logic [31:0] run_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]  m_err = 2'd0;
    logic [31:0] p_data [32];
    logic [5:0]  p_addr [32];
    logic [3:0]  p_hops [32];

    always #5 clk = ~clk;

    instr_chain_loader #(
        .INSTR_DATA_WIDTH(32),
        .INSTR_ADDR_WIDTH(6),
        .INSTR_HOPS_WIDTH(4),
        .NUM_CELLS(NC),
        .DRAIN_CYCLES(DR),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ld_valid(ld_valid),
        .ld_ready(ld_ready),
        .ld_data(ld_data),
        .ld_addr(ld_addr),
        .ld_hops(ld_hops),
        .ld_last(ld_last),
        .instr_data_out(instr_data_out),
        .instr_addr_out(instr_addr_out),
        .instr_hops_out(instr_hops_out),
        .instr_en_out(instr_en_out),
        .call_out(call_out),
        .ret_in(ret_in),
        .busy(busy),
        .done(done),
        .err(err),
        .run_cycles(run_cycles)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Drives n records, then walks the drain; stops after 'stop' drain cycles,
    // or (stop >= DR) ends in the call cycle.
    task automatic load_program(input int n, input bit gaps, input int stop);
        int  i = 0;
        int  guard = 0;
        bit  acc;
        bit  exp_en;
        while (i < n) begin
            ld_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            ld_data  = p_data[i];
            ld_addr  = p_addr[i];
            ld_hops  = p_hops[i];
            ld_last  = (i == n - 1);
            n_checks++;
            if (ld_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL load_ready rec %0d: got %b expected 1", i, ld_ready);
            end
            acc = ld_valid;
            step;
            exp_en = acc && (int'(p_hops[i]) < NC);
            if (acc) m_err = (int'(p_hops[i]) < NC) ? 2'd0 : 2'd1;
            n_checks++;
            if (instr_en_out !== exp_en) begin
                n_fail++;
                $display("FAIL instr_en rec %0d: got %b expected %b", i, instr_en_out, exp_en);
            end
            if (exp_en) begin
                n_checks++;
                if ({instr_data_out, instr_addr_out, instr_hops_out} !== {p_data[i], p_addr[i], p_hops[i]}) begin
                    n_fail++;
                    $display("FAIL chain_fields rec %0d: got %h/%h/%h expected %h/%h/%h", i,
                             instr_data_out, instr_addr_out, instr_hops_out, p_data[i], p_addr[i], p_hops[i]);
                end
            end
            n_checks++;
            if (err !== m_err) begin
                n_fail++;
                $display("FAIL load_err rec %0d: got %0d expected %0d", i, err, m_err);
            end
            if (acc) i++;
            guard++;
            if (guard > 1000) begin
                n_fail++;
                $display("FAIL load_timeout: got %0d accepted expected %0d", i, n);
                i = n;
            end
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        n_checks++;
        if ({ld_ready, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL drain_entry ready/busy: got %b%b expected 01", ld_ready, busy);
        end
        for (int j = 1; j < DR; j++) begin
            if (j > stop) return;
            step;
            n_checks++;
            if ({call_out, instr_en_out, ld_ready, busy} !== 4'b0001) begin
                n_fail++;
                $display("FAIL drain cycle %0d call/en/ready/busy: got %b%b%b%b expected 0001",
                         j, call_out, instr_en_out, ld_ready, busy);
            end
        end
        if (stop < DR) return;
        step;
        n_checks++;
        if ({call_out, run_cycles} !== {1'b1, 32'd0}) begin
            n_fail++;
            $display("FAIL call_cycle call/run: got %b/%0d expected 1/0", call_out, run_cycles);
        end
    endtask

    // Raises ret k cycles after the call cycle and checks the completion.
    task automatic ret_phase(input int k);
        ret_in = 1'b0;
        for (int j = 1; j <= k; j++) begin
            step;
            if (j == k) ret_in = 1'b1;
            n_checks++;
            if ({call_out, done, busy} !== 3'b001) begin
                n_fail++;
                $display("FAIL wait cycle %0d call/done/busy: got %b%b%b expected 001", j, call_out, done, busy);
            end
        end
        step;
        n_checks++;
        if ({done, ld_ready, busy, err, run_cycles} !== {1'b1, 1'b1, 1'b0, m_err, 32'(k)}) begin
            n_fail++;
            $display("FAIL ret_done done/ready/busy/err/run: got %b%b%b/%0d/%0d expected 110/%0d/%0d",
                     done, ld_ready, busy, err, run_cycles, m_err, k);
        end
        step;
        ret_in = 1'b0;
        n_checks++;
        if ({done, run_cycles} !== {1'b0, 32'(k)}) begin
            n_fail++;
            $display("FAIL ret_hold done/run: got %b/%0d expected 0/%0d", done, run_cycles, k);
        end
        $display("txn ret k=%0d err=%0d run=%0d", k, err, run_cycles);
    endtask

    // mode 0: idle reset, 1: reset mid-drain, 2: reset mid-wait.
    task automatic test_reset(input int mode);
        logic [45:0] rst_vec;
        logic [45:0] got;
        rst_vec = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 8'd0};
        if (mode == 1) begin
            p_data[0] = 32'h1111; p_addr[0] = 6'd3; p_hops[0] = 4'd2;
            p_data[1] = 32'h2222; p_addr[1] = 6'd4; p_hops[1] = 4'd14;
            load_program(2, 1'b0, 5);
        end else if (mode == 2) begin
            p_data[0] = 32'h3333; p_addr[0] = 6'd5; p_hops[0] = 4'd7;
            load_program(1, 1'b0, DR);
            ret_in = 1'b0;
            repeat (5) step;
        end
        rst = 1'b1;
        step;
        got = {ld_ready, instr_en_out, call_out, busy, done, err, run_cycles,
               instr_data_out[7:0] | instr_data_out[15:8] | instr_data_out[23:16] | instr_data_out[31:24]
               | {2'b0, instr_addr_out} | {4'b0, instr_hops_out}};
        n_checks++;
        if (got !== rst_vec || instr_data_out !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_values mode %0d: got %h expected %h", mode, got, rst_vec);
        end
        rst = 1'b0;
        m_err = 2'd0;
        for (int j = 0; j < DR + 4; j++) begin
            step;
            n_checks++;
            if ({ld_ready, call_out, busy, done, err} !== 6'b100000) begin
                n_fail++;
                $display("FAIL post_reset mode %0d cycle %0d ready/call/busy/done/err: got %b%b%b%b%0d expected 1000 err0",
                         mode, j, ld_ready, call_out, busy, done, err);
            end
        end
        $display("txn reset mode=%0d", mode);
    endtask

    task automatic test_basic;
        for (int i = 0; i < 3; i++) begin
            p_data[i] = 32'hA0 + 32'(i);
            p_addr[i] = 6'(i);
            p_hops[i] = 4'(i);
        end
        load_program(3, 1'b0, DR);
        ret_phase(7);
    endtask

    task automatic test_bad_hops;
        p_data[0] = $urandom; p_addr[0] = 6'($urandom); p_hops[0] = 4'($urandom_range(NC, 15));
        p_data[1] = $urandom; p_addr[1] = 6'($urandom); p_hops[1] = 4'($urandom_range(0, NC - 1));
        p_data[2] = $urandom; p_addr[2] = 6'($urandom); p_hops[2] = 4'($urandom_range(NC, 15));
        load_program(3, 1'b0, DR);
        ret_phase($urandom_range(1, 10));
        p_data[0] = $urandom; p_addr[0] = 6'($urandom); p_hops[0] = 4'($urandom_range(0, NC - 1));
        load_program(1, 1'b0, DR);
        ret_phase($urandom_range(1, 10));
    endtask

    task automatic test_stale;
        p_data[0] = 32'hBEEF; p_addr[0] = 6'd9; p_hops[0] = 4'd1;
        p_data[1] = 32'hCAFE; p_addr[1] = 6'd10; p_hops[1] = 4'd11;
        ret_in = 1'b1;
        load_program(2, 1'b1, DR);
        step;
        m_err = 2'd2;
        n_checks++;
        if ({done, call_out, ld_ready, busy, err, run_cycles} !== {4'b1010, 2'd2, 32'd0}) begin
            n_fail++;
            $display("FAIL stale done/call/ready/busy/err/run: got %b%b%b%b/%0d/%0d expected 1010/2/0",
                     done, call_out, ld_ready, busy, err, run_cycles);
        end
        step;
        ret_in = 1'b0;
        n_checks++;
        if ({done, busy, err} !== {2'b00, 2'd2}) begin
            n_fail++;
            $display("FAIL stale_after done/busy/err: got %b%b/%0d expected 00/2", done, busy, err);
        end
        $display("txn stale err=%0d", err);
    endtask

    task automatic test_timeout;
        p_data[0] = 32'h5A5A; p_addr[0] = 6'd63; p_hops[0] = 4'd0;
        load_program(1, 1'b0, DR);
        ret_in = 1'b0;
        for (int j = 1; j <= TO; j++) begin
            step;
            n_checks++;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_early cycle %0d: got done %b expected 0", j, done);
            end
        end
        step;
        m_err = 2'd3;
        n_checks++;
        if ({done, ld_ready, busy, err, run_cycles} !== {3'b110, 2'd3, 32'(TO)}) begin
            n_fail++;
            $display("FAIL timeout done/ready/busy/err/run: got %b%b%b/%0d/%0d expected 110/3/%0d",
                     done, ld_ready, busy, err, run_cycles, TO);
        end
        step;
        $display("txn timeout err=%0d run=%0d", err, run_cycles);
    endtask

    task automatic test_random;
        int n;
        for (int p = 0; p < 6; p++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                p_data[i] = $urandom;
                p_addr[i] = 6'($urandom);
                p_hops[i] = 4'($urandom_range(0, 15));
            end
            load_program(n, 1'($urandom_range(0, 1)), DR);
            ret_phase($urandom_range(1, 40));
        end
    endtask

    initial begin
        test_reset(0);
        test_basic;
        test_bad_hops;
        test_stale;
        test_timeout;
        test_reset(1);
        test_random;
        test_reset(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
